// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM (IF/ID/EX/MEM/WB) with bounded memory wait and sticky error state.
// Optional instruction counter output instr_cnt_o when MULTICYCLE_CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_src_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       alu_src_o,
    output logic       mem_to_reg_o,
    output logic [1:0] alu_op_o,
    output logic       reg_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic [2:0] state_o,
    output logic       err_o
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] instr_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [7:0] MEM_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_next;
    logic [5:0] op_q;
    logic [7:0] mem_cnt;

    logic is_r, is_addi, is_lw, is_sw, is_beq, is_legal;

    assign is_r     = (op_q == OP_RTYPE);
    assign is_addi  = (op_q == OP_ADDI);
    assign is_lw    = (op_q == OP_LW);
    assign is_sw    = (op_q == OP_SW);
    assign is_beq   = (op_q == OP_BEQ);
    assign is_legal = is_r | is_addi | is_lw | is_sw | is_beq;

    // mem_cnt holds the number of MEM cycles already spent without mem_ready_i.
    // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            op_q    <= '0;
            mem_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_IF) begin
                op_q <= op_i;
            end
            if (state == S_MEM && !mem_ready_i) begin
                mem_cnt <= mem_cnt + 8'd1;
            end else begin
                mem_cnt <= '0;
            end
        end
    end

    // NOTE: every output and next-state gets a default first, so no latches can be inferred.
    always_comb begin
        state_next   = state;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        alu_src_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_op_o     = 2'b00;
        reg_write_o  = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        err_o        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_i) state_next = S_IF;
            end
            S_IF: begin
                ir_write_o = 1'b1;
                state_next = S_ID;
            end
            S_ID: begin
                state_next = is_legal ? S_EX : S_ERR;
            end
            S_EX: begin
                if (is_r) begin
                    alu_op_o   = 2'b10;
                    state_next = S_WB;
                end else if (is_addi) begin
                    alu_src_o  = 1'b1;
                    state_next = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_src_o  = 1'b1;
                    state_next = S_MEM;
                end else if (is_beq) begin
                    alu_op_o   = 2'b01;
                    pc_write_o = 1'b1;
                    pc_src_o   = zero_i;
                    state_next = start_i ? S_IF : S_IDLE;
                end else begin
                    state_next = S_ERR;
                end
            end
            S_MEM: begin
                mem_read_o  = is_lw;
                mem_write_o = is_sw;
                if (mem_ready_i) begin
                    if (is_sw) begin
                        pc_write_o = 1'b1;
                        state_next = start_i ? S_IF : S_IDLE;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (mem_cnt == MEM_LAST) begin
                    state_next = S_ERR;
                end
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                pc_write_o   = 1'b1;
                reg_dst_o    = is_r;
                mem_to_reg_o = is_lw;
                state_next   = start_i ? S_IF : S_IDLE;
            end
            S_ERR: begin
                err_o      = 1'b1;
                state_next = S_ERR;
            end
            default: begin
                state_next = S_ERR;
            end
        endcase
    end

    assign state_o = state;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            instr_cnt_o <= '0;
        end else if (pc_write_o) begin
            instr_cnt_o <= instr_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL be the maximum number of MEM-state cycles to wait for mem_ready_i; legal range 1..255.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-low.
REQ-004 start_i  input  1  run enable; high = keep executing instructions.
REQ-005 op_i  input  6  opcode field inst[31:26] from instruction memory.
REQ-006 zero_i  input  1  ALU zero flag, sampled in EX for beq.
REQ-007 mem_ready_i  input  1  data-memory completion handshake.
REQ-008 pc_write_o  output  1  PC load enable, one pulse per retired instruction.
REQ-009 pc_src_o  output  1  0 = PC+4, 1 = branch target.
REQ-010 ir_write_o  output  1  instruction/opcode register load.
REQ-011 reg_dst_o, alu_src_o, mem_to_reg_o  output  1 each  datapath mux selects.
REQ-012 alu_op_o  output  2  00 add, 01 sub, 10 funct-decoded.
REQ-013 reg_write_o, mem_read_o, mem_write_o  output  1 each  write/access enables.
REQ-014 state_o  output  3  current state encoding; err_o  output  1  sticky error flag.

Function
REQ-015 States SHALL be IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, ERR=6; code 7 SHALL go to ERR.
REQ-016 IDLE: start_i=1 -> IF next cycle; otherwise stay in IDLE.
REQ-017 IF: ir_write_o=1 for exactly one cycle; the internal opcode register SHALL capture op_i; -> ID.
REQ-018 ID: decode the latched opcode; R-type 000000, addi 001000, lw 100011, sw 101011, beq 000100 -> EX; any other opcode -> ERR.
REQ-019 EX: R-type/addi -> WB; lw/sw -> MEM; beq -> pc_write_o=1, pc_src_o=zero_i, then IF if start_i=1, else IDLE.
REQ-020 EX control: R-type alu_op_o=10, alu_src_o=0; addi/lw/sw alu_op_o=00, alu_src_o=1; beq alu_op_o=01, alu_src_o=0.
REQ-021 MEM: mem_read_o (lw) or mem_write_o (sw) SHALL stay high until the cycle mem_ready_i=1 is sampled; lw -> WB; sw -> pc_write_o=1 in that cycle, then IF/IDLE per start_i.
REQ-022 MEM timeout: after TIMEOUT consecutive MEM cycles without mem_ready_i -> ERR; mem_ready_i in cycle TIMEOUT itself SHALL count as success.
REQ-023 WB: reg_write_o=1, pc_write_o=1, pc_src_o=0; reg_dst_o=1 for R-type, 0 otherwise; mem_to_reg_o=1 for lw only; -> IF if start_i=1, else IDLE.
REQ-024 start_i deassertion mid-instruction SHALL NOT abort; the current instruction completes, then IDLE.
REQ-025 ERR: all enables 0, err_o=1, held until reset regardless of start_i.
REQ-026 All outputs SHALL be Moore functions of the state and latched opcode, except pc_src_o in EX (follows zero_i).
REQ-027 Per-instruction latency: beq 3, R-type/addi 4, sw 3+N, lw 4+N cycles, N = MEM cycles (1..TIMEOUT).

Reset
REQ-028 rst_i low SHALL immediately force IDLE, clear opcode register, timeout counter and err_o, and drive every output to 0, in any state.
REQ-029 First transition after rst_i rises SHALL occur on the next clk_i edge with start_i=1.

Configuration
REQ-030 Macro MULTICYCLE_CTRL_PERF_CNT_EN defined: add output instr_cnt_o (32-bit) incrementing on every pc_write_o cycle, wrapping from FFFFFFFF to 0, reset to 0.
REQ-031 Macro undefined: instr_cnt_o and its counter SHALL NOT exist; all other behaviour identical.

Verification
REQ-032 Reset, start_i=1, op_i=000000 -> states 1,2,3,5,1; reg_write_o and pc_write_o high in WB only; reg_dst_o=1.
REQ-033 lw, mem_ready_i high on 3rd MEM cycle -> mem_read_o high 3 cycles, WB with mem_to_reg_o=1; total 7 cycles.
REQ-034 beq with zero_i=1 -> EX cycle has pc_write_o=1, pc_src_o=1, next state IF; zero_i=0 -> pc_src_o=0.
REQ-035 sw, mem_ready_i never high, TIMEOUT=15 -> ERR after 15 MEM cycles, err_o=1, stays with start_i toggling.
REQ-036 op_i=111111 -> ERR from ID; rst_i pulsed low mid-MEM -> outputs 0, state_o=0 without clock edge.
